// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - CPU memory bus bundle shared by both arbiter masters and the slave port
interface mem_arbiter_if;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [3:0]  byte_enable;
  logic        write_req;
  logic        read_req;
  logic        ready;
  logic [31:0] read_data;
  logic        read_data_valid;

  modport master (
    output addr, write_data, byte_enable, write_req, read_req,
    input  ready, read_data, read_data_valid
  );

  modport slave (
    input  addr, write_data, byte_enable, write_req, read_req,
    output ready, read_data, read_data_valid
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-master round-robin memory arbiter with read-tag FIFO for return routing
module mem_arbiter #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  mem_arbiter_if.slave  m0,
  mem_arbiter_if.slave  m1,
  mem_arbiter_if.master s,
  output logic          error
);
  localparam int PW = $clog2(MAX_OUTSTANDING);

  logic          prio;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          tags [MAX_OUTSTANDING];
  logic          error_q;

  logic full, empty;
  logic elig0, elig1, grant0, grant1;
  logic accept, push, pop, head;

  // Depth is a power of two, so the count MSB alone means full.
  assign full  = count[PW];
  assign empty = (count == '0);

  assign elig0 = (m0.write_req | m0.read_req) & ~(m0.read_req & full);
  assign elig1 = (m1.write_req | m1.read_req) & ~(m1.read_req & full);

  assign grant0 = elig0 & (~elig1 | ~prio);
  assign grant1 = elig1 & (~elig0 |  prio);

  always_comb begin
    s.addr        = '0;
    s.write_data  = '0;
    s.byte_enable = '0;
    s.write_req   = 1'b0;
    s.read_req    = 1'b0;
    if (grant0) begin
      s.addr        = m0.addr;
      s.write_data  = m0.write_data;
      s.byte_enable = m0.byte_enable;
      s.write_req   = m0.write_req;
      s.read_req    = m0.read_req;
    end else if (grant1) begin
      s.addr        = m1.addr;
      s.write_data  = m1.write_data;
      s.byte_enable = m1.byte_enable;
      s.write_req   = m1.write_req;
      s.read_req    = m1.read_req;
    end
  end

  assign m0.ready = grant0 & s.ready;
  assign m1.ready = grant1 & s.ready;

  assign accept = (grant0 | grant1) & s.ready;
  assign push   = accept & s.read_req;
  assign pop    = s.read_data_valid & ~empty;
  assign head   = tags[rd_ptr];

  assign m0.read_data       = s.read_data;
  assign m1.read_data       = s.read_data;
  assign m0.read_data_valid = pop & ~head;
  assign m1.read_data_valid = pop &  head;

  assign error = error_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio    <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      error_q <= 1'b0;
    end else begin
      if (accept)
        prio <= grant0;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (s.read_data_valid & empty)
        error_q <= 1'b1;
    end
  end

  // Tag storage needs no reset: entries are only read below a valid count.
  always_ff @(posedge clk) begin
    if (push)
      tags[wr_ptr] <= grant1;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic error;
  int   total = 0;
  int   bad = 0;

  mem_arbiter_if m0_bus ();
  mem_arbiter_if m1_bus ();
  mem_arbiter_if s_bus ();

  mem_arbiter #(.MAX_OUTSTANDING(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .m0      (m0_bus),
    .m1      (m1_bus),
    .s       (s_bus),
    .error   (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    m0_bus.addr = '0; m0_bus.write_data = '0; m0_bus.byte_enable = '0;
    m0_bus.write_req = 1'b0; m0_bus.read_req = 1'b0;
    m1_bus.addr = '0; m1_bus.write_data = '0; m1_bus.byte_enable = '0;
    m1_bus.write_req = 1'b0; m1_bus.read_req = 1'b0;
    s_bus.ready = 1'b1; s_bus.read_data = '0; s_bus.read_data_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic m0_req(input logic [31:0] a, input logic rd);
    m0_bus.addr = a; m0_bus.write_data = ~a; m0_bus.byte_enable = 4'hf;
    m0_bus.read_req = rd; m0_bus.write_req = ~rd;
  endtask

  task automatic m1_req(input logic [31:0] a, input logic rd);
    m1_bus.addr = a; m1_bus.write_data = ~a; m1_bus.byte_enable = 4'h3;
    m1_bus.read_req = rd; m1_bus.write_req = ~rd;
  endtask

  task automatic ret(input logic [31:0] d);
    s_bus.read_data = d; s_bus.read_data_valid = 1'b1;
  endtask

  initial begin
    idle();
    s_bus.ready = 1'b0;
    #2;
    check("rst_error", error, 0);
    check("rst_s_req", {s_bus.write_req, s_bus.read_req}, 0);
    check("rst_s_addr", s_bus.addr, 0);
    check("rst_m0_ready", m0_bus.ready, 0);
    step(); step();
    reset_n = 1'b1;

    // contention: both write every cycle, grants must alternate starting at m0
    for (int i = 0; i < 4; i++) begin
      step(); idle();
      m0_req(32'h0000_00a0, 1'b0);
      m1_req(32'h0000_00b0, 1'b0);
      #1;
      check("cont_m0_ready", m0_bus.ready, (i % 2 == 0) ? 1 : 0);
      check("cont_m1_ready", m1_bus.ready, (i % 2 == 1) ? 1 : 0);
      check("cont_s_addr", s_bus.addr, (i % 2 == 0) ? 32'ha0 : 32'hb0);
      check("cont_s_be", s_bus.byte_enable, (i % 2 == 0) ? 4'hf : 4'h3);
    end

    // single master read
    step(); idle(); m0_req(32'h1000_0000, 1'b1); #1;
    check("rd_m0_ready", m0_bus.ready, 1);
    check("rd_s_read_req", s_bus.read_req, 1);
    check("rd_s_addr", s_bus.addr, 32'h1000_0000);
    step(); idle(); #1;
    check("rd_m0_ready_off", m0_bus.ready, 0);
    step(); idle(); ret(32'hdead_beef); #1;
    check("rd_m0_valid", m0_bus.read_data_valid, 1);
    check("rd_m0_data", m0_bus.read_data, 32'hdead_beef);
    check("rd_m1_valid", m1_bus.read_data_valid, 0);

    // interleaved reads m1, m0, m1 then in-order returns
    step(); idle(); m1_req(32'h100, 1'b1); #1;
    check("il_m1_ready_a", m1_bus.ready, 1);
    step(); idle(); m0_req(32'h200, 1'b1); #1;
    check("il_m0_ready_b", m0_bus.ready, 1);
    step(); idle(); m1_req(32'h300, 1'b1); #1;
    check("il_m1_ready_c", m1_bus.ready, 1);
    step(); idle(); ret(32'h1); #1;
    check("il_ret1", {m1_bus.read_data_valid, m0_bus.read_data_valid, m1_bus.read_data}, {2'b10, 32'h1});
    step(); idle(); ret(32'h2); #1;
    check("il_ret2", {m1_bus.read_data_valid, m0_bus.read_data_valid, m0_bus.read_data}, {2'b01, 32'h2});
    step(); idle(); ret(32'h3); #1;
    check("il_ret3", {m1_bus.read_data_valid, m0_bus.read_data_valid, m1_bus.read_data}, {2'b10, 32'h3});

    // fill the tag FIFO from m0
    for (int i = 0; i < 4; i++) begin
      step(); idle(); m0_req(32'h400 + i, 1'b1); #1;
      check("full_fill_ready", m0_bus.ready, 1);
    end
    step(); idle(); m0_req(32'h500, 1'b1); m1_req(32'h600, 1'b0); #1;
    check("full_m0_blocked", m0_bus.ready, 0);
    check("full_m1_write", m1_bus.ready, 1);
    check("full_s_addr", s_bus.addr, 32'h600);
    step(); idle(); m0_req(32'h500, 1'b1); ret(32'h40); #1;
    check("full_pop_blocked", m0_bus.ready, 0);
    check("full_pop_valid", m0_bus.read_data_valid, 1);
    step(); idle(); m0_req(32'h500, 1'b1); #1;
    check("full_after_pop", m0_bus.ready, 1);
    for (int i = 0; i < 4; i++) begin
      step(); idle(); ret(32'h50 + i); #1;
      check("full_drain", {m1_bus.read_data_valid, m0_bus.read_data_valid}, 2'b01);
    end

    // slave stall under m0 write; priority pointer must not move
    for (int i = 0; i < 3; i++) begin
      step(); idle(); s_bus.ready = 1'b0; m0_req(32'h55, 1'b0); #1;
      check("stall_m0_ready", m0_bus.ready, 0);
      check("stall_s_addr", s_bus.addr, 32'h55);
      check("stall_s_wr", {s_bus.write_req, s_bus.write_data}, {1'b1, ~32'h55});
    end
    step(); idle(); s_bus.ready = 1'b0; m0_req(32'h55, 1'b0); m1_req(32'h66, 1'b0); #1;
    check("stall_prio_held", s_bus.addr, 32'h66);
    step(); idle(); m0_req(32'h55, 1'b0); m1_req(32'h66, 1'b0); #1;
    check("stall_m1_accept", {m1_bus.ready, m0_bus.ready}, 2'b10);
    step(); idle(); m0_req(32'h55, 1'b0); #1;
    check("stall_m0_accept", m0_bus.ready, 1);

    // orphan return, sticky error, reset clears it and discards tags
    step(); idle(); ret(32'h77); #1;
    check("orph_no_valid", {m1_bus.read_data_valid, m0_bus.read_data_valid}, 2'b00);
    check("orph_error_same", error, 0);
    step(); idle(); #1;
    check("orph_error_set", error, 1);
    step(); idle(); m0_req(32'h88, 1'b1); #1;
    check("orph_error_sticky", error, 1);
    check("orph_rd_accept", m0_bus.ready, 1);
    step(); idle(); reset_n = 1'b0; #1;
    check("rst_clears_error", error, 0);
    step();
    reset_n = 1'b1;
    step(); idle(); ret(32'h99); #1;
    check("rst_tag_dropped", {m1_bus.read_data_valid, m0_bus.read_data_valid}, 2'b00);
    step(); idle(); #1;
    check("rst_orphan_error", error, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master, one-slave arbiter for the system memory bus. It shares one memory port between the CPU (master 0) and a second requester such as a program loader or DMA engine (master 1). Both sides of the arbiter use the CPU bus protocol: `ready`, `addr`, `write_data`, `byte_enable`, `write_req`, `read_req`, `read_data` and `read_data_valid`. Request arbitration is round-robin. A tag FIFO routes each returning read to the master that issued it, so the slave can keep reads pipelined.

## Interface
- `MAX_OUTSTANDING`, default 4: depth of the read-tag FIFO, i.e. reads accepted but not yet returned. Power of two, ≥2.
- `clk` in 1: clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `mN_addr` in 32, N∈{0,1}: master N address.
- `mN_write_data` in 32: master N write data.
- `mN_byte_enable` in 4: master N byte enables.
- `mN_write_req` in 1: master N write request.
- `mN_read_req` in 1: master N read request.
- `mN_ready` out 1: master N request is accepted this cycle.
- `mN_read_data` out 32: read data to master N.
- `mN_read_data_valid` out 1: read data to master N is valid.
- `s_addr`, `s_write_data`, `s_byte_enable`, `s_write_req`, `s_read_req` out 32/32/4/1/1: slave request.
- `s_ready` in 1: slave accepts the presented request.
- `s_read_data` in 32: slave read data.
- `s_read_data_valid` in 1: slave read data valid.
- `error` out 1: sticky flag, set on a read return with no outstanding tag.

## Operation
- **Protocol.** A master holds its request fields stable until the cycle its `mN_ready`=1; acceptance is that cycle. `write_req` and `read_req` are never both high from one master.
- **Request.** Master N requests when `mN_write_req | mN_read_req`.
- **Eligibility.** Master N is eligible when it requests and, for reads, the tag FIFO is not full.
- **Grant (combinational each cycle).**
  - Only one master eligible: grant it.
  - Both eligible: grant the master the registered `prio` pointer selects.
  - No master eligible: no grant.
- **Slave drive.** The granted master's fields are forwarded to `s_*`. With no grant, all `s_*` outputs are 0.
- **Ready.** `mN_ready` = granted(N) & `s_ready`. It is 0 for a non-granted master and for a master blocked only by a full FIFO.
- **Priority update.** On acceptance by master N, `prio` ← 1−N. With no acceptance, `prio` holds.
- **Tag FIFO.** An accepted read pushes the master index. Accepted writes push nothing and never block.
- **Read return.** `s_read_data_valid`=1 with the FIFO non-empty pops the head tag T.
  - `mT_read_data_valid`=1 and `mT_read_data`=`s_read_data`, combinationally.
  - The other master's `read_data_valid`=0.
  - Both `mN_read_data` always carry `s_read_data`; only the valid is gated.
- **Orphan return.** `s_read_data_valid` with the FIFO empty: the data is dropped, `error`←1, and `error` stays 1 until reset.
- **Push and pop together.** Both take effect and the count is unchanged. A full FIFO with a simultaneous pop still blocks new reads this cycle, because eligibility uses the registered count.
- **Pointers.** The FIFO read and write pointers wrap modulo `MAX_OUTSTANDING`. A count register of width log2(`MAX_OUTSTANDING`)+1 tracks occupancy.

## Timing
- Request path is zero-latency combinational: master to `s_*`, and `s_ready` to `mN_ready`.
- Return path is combinational: `s_read_data_valid` to `mN_read_data_valid`.
- The slave must return data at least one cycle after acceptance. A return in the acceptance cycle is an orphan if the FIFO was empty.
- State (`prio`, FIFO, count, `error`) updates on the rising `clk` edge.
- Reset values: `prio`=0 (master 0 first), FIFO empty, count=0, `error`=0.
  - All `s_*` request outputs are 0 while no master requests.
  - All `mN_ready` and `mN_read_data_valid` are 0 unless driven by inputs as above.
- Reset mid-operation: outstanding tags are discarded. Returns arriving after reset deassertion are orphans and set `error`.
- Returns are in order; the slave must not reorder reads.

## Test plan
- **Single master read.** m0 read at 0x10000000; `s_ready`=1, slave returns 0xDEADBEEF two cycles later.
  - Required: `m0_ready` pulses once; `m0_read_data_valid`=1 with 0xDEADBEEF; m1 sees no valid.
- **Contention.** Both masters request writes every cycle, `s_ready`=1.
  - Required: grants alternate m0, m1, m0, m1; `s_addr` follows the granted master's address each cycle.
- **Interleaved reads.** Reads accepted in order m1, m0, m1; slave returns 0x1, 0x2, 0x3.
  - Required: m1 gets 0x1 and 0x3; m0 gets 0x2.
- **FIFO full.** With `MAX_OUTSTANDING`=4, m0 issues 4 reads with no return.
  - Required: a 5th m0 read sees `m0_ready`=0 while an m1 write is still accepted.
  - After one return, the 5th read is accepted the following cycle.
- **Slave stall.** `s_ready`=0 for 3 cycles under an m0 write.
  - Required: `m0_ready`=0 throughout; `s_*` stays stable; `prio` is unchanged until acceptance.
- **Orphan and reset.** `s_read_data_valid`=1 with no outstanding read.
  - Required: `error`=1 from the next cycle and no master valid.
  - Assert `reset_n`=0: `error`=0 and count=0 immediately.
